// File: rtl/mandelbrot_pkg.sv
// Shared widths and sequencer state encoding for the Mandelbrot pixel pipeline.
package mandelbrot_pkg;

  localparam int unsigned PX_W  = 10;
  localparam int unsigned PY_W  = 9;
  localparam int unsigned RGB_W = 24;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StPush
  } seq_state_e;

endpackage

// File: rtl/mandelbrot_raster_counter.sv
// Raster position register: clears to (0,0), advances left-to-right then top-to-bottom.
module mandelbrot_raster_counter
  import mandelbrot_pkg::*;
#(
  parameter int unsigned H_RES = 640,
  parameter int unsigned V_RES = 480
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            clr,
  input  logic            adv,
  output logic [PX_W-1:0] px,
  output logic [PY_W-1:0] py,
  output logic            is_first,
  output logic            is_eol,
  output logic            is_last
);

  localparam logic [PX_W-1:0] PxMax = PX_W'(H_RES - 1);
  localparam logic [PY_W-1:0] PyMax = PY_W'(V_RES - 1);

  logic [PX_W-1:0] px_q, px_d;
  logic [PY_W-1:0] py_q, py_d;

  assign px       = px_q;
  assign py       = py_q;
  assign is_first = (px_q == '0) && (py_q == '0);
  assign is_eol   = (px_q == PxMax);
  assign is_last  = is_eol && (py_q == PyMax);

  always_comb begin
    px_d = px_q;
    py_d = py_q;
    if (clr) begin
      px_d = '0;
      py_d = '0;
    end else if (adv) begin
      if (is_eol) begin
        px_d = '0;
        py_d = is_last ? '0 : py_q + PY_W'(1);
      end else begin
        px_d = px_q + PX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      px_q <= '0;
      py_q <= '0;
    end else begin
      px_q <= px_d;
      py_q <= py_d;
    end
  end

endmodule

// File: rtl/mandelbrot_pixel_sequencer.sv
// Walks one raster frame through the per-pixel compute core and streams the colours out.
module mandelbrot_pixel_sequencer
  import mandelbrot_pkg::*;
#(
  parameter int unsigned H_RES   = 640,
  parameter int unsigned V_RES   = 480,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             frame_go,
  output logic             core_start,
  output logic [PX_W-1:0]  core_px,
  output logic [PY_W-1:0]  core_py,
  input  logic             core_done,
  input  logic [RGB_W-1:0] core_rgb,
  output logic [RGB_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sof,
  output logic             out_eol,
  output logic             busy,
  output logic             frame_done,
  output logic             timeout_err
);

  localparam int unsigned     CntW   = $clog2(TIMEOUT);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

  seq_state_e       state_q, state_d;
  logic [CntW-1:0]  wait_cnt_q, wait_cnt_d;
  logic [RGB_W-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             out_sof_q, out_sof_d;
  logic             out_eol_q, out_eol_d;
  logic             frame_done_q, frame_done_d;
  logic             timeout_err_q, timeout_err_d;
  logic             core_start_q, core_start_d;
  logic             busy_q, busy_d;
  logic             clr, adv;
  logic             is_first, is_eol, is_last;

  mandelbrot_raster_counter #(
    .H_RES (H_RES),
    .V_RES (V_RES)
  ) u_raster (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr      (clr),
    .adv      (adv),
    .px       (core_px),
    .py       (core_py),
    .is_first (is_first),
    .is_eol   (is_eol),
    .is_last  (is_last)
  );

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    out_data_d    = out_data_q;
    out_valid_d   = out_valid_q;
    out_sof_d     = out_sof_q;
    out_eol_d     = out_eol_q;
    timeout_err_d = timeout_err_q;
    frame_done_d  = 1'b0;
    clr           = 1'b0;
    adv           = 1'b0;
    case (state_q)
      StIdle: begin
        if (frame_go) begin
          clr           = 1'b1;
          timeout_err_d = 1'b0;
          state_d       = StIssue;
        end
      end
      StIssue: begin
        wait_cnt_d = '0;
        state_d    = StWait;
      end
      StWait: begin
        // A completion in the final allowed cycle still counts as on time.
        if (core_done || (wait_cnt_q == CntMax)) begin
          out_data_d  = core_done ? core_rgb : '0;
          out_valid_d = 1'b1;
          out_sof_d   = is_first;
          out_eol_d   = is_eol;
          if (!core_done) begin
            timeout_err_d = 1'b1;
          end
          state_d = StPush;
        end else begin
          wait_cnt_d = wait_cnt_q + CntW'(1);
        end
      end
      StPush: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          out_sof_d   = 1'b0;
          out_eol_d   = 1'b0;
          if (is_last) begin
            frame_done_d = 1'b1;
            state_d      = StIdle;
          end else begin
            adv     = 1'b1;
            state_d = StIssue;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    // Registered from the next state so the pulse lines up with the ISSUE cycle itself.
    core_start_d = (state_d == StIssue);
    busy_d       = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      wait_cnt_q    <= '0;
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
      out_sof_q     <= 1'b0;
      out_eol_q     <= 1'b0;
      frame_done_q  <= 1'b0;
      timeout_err_q <= 1'b0;
      core_start_q  <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      out_data_q    <= out_data_d;
      out_valid_q   <= out_valid_d;
      out_sof_q     <= out_sof_d;
      out_eol_q     <= out_eol_d;
      frame_done_q  <= frame_done_d;
      timeout_err_q <= timeout_err_d;
      core_start_q  <= core_start_d;
      busy_q        <= busy_d;
    end
  end

  assign core_start  = core_start_q;
  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign out_sof     = out_sof_q;
  assign out_eol     = out_eol_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mandelbrot_pixel_sequencer.sv
// Scoreboard bench: a frame-level model predicts every pixel; a monitor checks the stream.
module tb_mandelbrot_pixel_sequencer;

  localparam int H    = 4;
  localparam int V    = 2;
  localparam int TO   = 16;
  localparam int NPIX = H * V;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        frame_go;
  logic        core_start;
  logic [9:0]  core_px;
  logic [8:0]  core_py;
  logic        core_done;
  logic [23:0] core_rgb;
  logic [23:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_sof;
  logic        out_eol;
  logic        busy;
  logic        frame_done;
  logic        timeout_err;

  always #5 clk = ~clk;

  mandelbrot_pixel_sequencer #(
    .H_RES   (H),
    .V_RES   (V),
    .TIMEOUT (TO)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .frame_go    (frame_go),
    .core_start  (core_start),
    .core_px     (core_px),
    .core_py     (core_py),
    .core_done   (core_done),
    .core_rgb    (core_rgb),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sof     (out_sof),
    .out_eol     (out_eol),
    .busy        (busy),
    .frame_done  (frame_done),
    .timeout_err (timeout_err)
  );

  typedef struct packed {
    logic [23:0] data;
    logic        sof;
    logic        eol;
    logic        last;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          dly[NPIX];   // core answer delay per pixel in cycles after start; <=0 means never
  logic [23:0] salt;
  bit          stray_en;
  int          ready_pct;
  int          bp_req;
  int          bp_done;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] pix_rgb(input int x, input int y);
    logic [26:0] w;
    w = {8'h00, 10'(x), 9'(y)};
    return w[23:0] ^ salt;
  endfunction

  function automatic bit on_time(input int d);
    return (d >= 1) && (d <= TO);
  endfunction

  // Reference model: every pixel in raster order, black if the core misses its window.
  task automatic push_frame();
    exp_t e;
    for (int y = 0; y < V; y++) begin
      for (int x = 0; x < H; x++) begin
        e.data = on_time(dly[y*H+x]) ? pix_rgb(x, y) : 24'h0;
        e.sof  = (x == 0) && (y == 0);
        e.eol  = (x == H - 1);
        e.last = (x == H - 1) && (y == V - 1);
        sb.push_back(e);
      end
    end
  endtask

  function automatic bit exp_err();
    for (int i = 0; i < NPIX; i++) if (!on_time(dly[i])) return 1'b1;
    return 1'b0;
  endfunction

  task automatic set_dly(input int d);
    for (int i = 0; i < NPIX; i++) dly[i] = d;
  endtask

  task automatic start_frame();
    @(negedge clk);
    frame_go = 1'b1;
    @(negedge clk);
    frame_go = 1'b0;
    check("busy_after_go", busy, 1);
    check("err_cleared_on_go", timeout_err, 0);
  endtask

  task automatic wait_frame_done(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < 4000);
    if (!frame_done) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: frame_done not seen within %0d cycles", name, n);
    end
  endtask

  task automatic run_frame(input string name);
    push_frame();
    start_frame();
    wait_frame_done(name);
    check({name, "_timeout_err"}, timeout_err, exp_err());
  endtask

  // Core model: answers each start after dly cycles; optionally sprays stray done pulses
  // while the sequencer is idle or presenting a pixel.
  initial begin
    int cnt;
    int cx;
    int cy;
    cnt = 0;
    cx = 0;
    cy = 0;
    core_done = 1'b0;
    core_rgb  = 24'h0;
    forever begin
      @(negedge clk);
      core_done = 1'b0;
      if (core_start) begin
        cx  = int'(core_px);
        cy  = int'(core_py);
        cnt = dly[cy*H+cx];
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          core_done = 1'b1;
          core_rgb  = pix_rgb(cx, cy);
        end
      end else if (stray_en && (!busy || out_valid)) begin
        core_done = 1'b1;
        core_rgb  = 24'h5a5a5a;
      end
    end
  end

  // Downstream ready: random acceptance, plus one 5-cycle stall on pixel (2,0) on request.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bp_req != bp_done && out_valid && core_px == 10'd2 && core_py == 9'd0) begin
        bp_done++;
        out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end else begin
        out_ready = (int'($urandom_range(99)) < ready_pct);
      end
    end
  end

  // Monitor: pops expectations on each handshake, checks holds under backpressure and frame_done.
  initial begin
    exp_t        e;
    bit          pend;
    bit          fd_exp;
    logic [23:0] pd;
    logic        ps;
    logic        pe;
    pend = 1'b0;
    fd_exp = 1'b0;
    pd = 24'h0;
    ps = 1'b0;
    pe = 1'b0;
    forever begin
      @(negedge clk);
      if (frame_done || fd_exp) begin
        check("frame_done", frame_done, fd_exp);
        if (fd_exp) check("busy_low_at_done", busy, 0);
      end
      fd_exp = 1'b0;
      if (pend) check("hold_under_backpressure", {out_valid, out_data, out_sof, out_eol},
                      {1'b1, pd, ps, pe});
      pend = 1'b0;
      if (out_valid) begin
        check("no_start_while_valid", core_start, 0);
        if (out_ready) begin
          if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_pixel: got data %0h with empty scoreboard", out_data);
          end else begin
            e = sb.pop_front();
            check("pixel", {out_data, out_sof, out_eol}, {e.data, e.sof, e.eol});
            fd_exp = e.last;
          end
        end else begin
          pend = 1'b1;
          pd = out_data;
          ps = out_sof;
          pe = out_eol;
        end
      end
    end
  end

  initial begin
    int n;
    reset_n   = 1'b0;
    frame_go  = 1'b0;
    salt      = 24'h0;
    stray_en  = 1'b0;
    ready_pct = 100;
    bp_req    = 0;
    bp_done   = 0;
    set_dly(3);
    repeat (3) @(negedge clk);
    check("reset_outputs", {core_start, core_px, core_py, out_data, out_valid, out_sof,
                            out_eol, busy, frame_done, timeout_err}, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    run_frame("basic");

    bp_req++;
    run_frame("backpressure");

    dly[1] = -1;
    run_frame("timeout");
    repeat (2) @(negedge clk);
    check("timeout_err_sticky", timeout_err, 1);

    set_dly(3);
    dly[2]   = 15;
    dly[6]   = 16;
    stray_en = 1'b1;
    run_frame("coincident_and_stray");
    stray_en = 1'b0;

    // Abort a frame with reset while the core is working on pixel (1,1).
    set_dly(3);
    push_frame();
    start_frame();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(core_start && core_px == 10'd1 && core_py == 9'd1) && n < 500);
    check("reached_pixel5", core_start, 1);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_outputs", {core_start, core_px, core_py, out_data, out_valid, out_sof,
                                  out_eol, busy, frame_done, timeout_err}, 0);
    sb.delete();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    run_frame("after_reset");

    // frame_go held high: one frame, one idle cycle, then exactly one more.
    push_frame();
    push_frame();
    @(negedge clk);
    frame_go = 1'b1;
    wait_frame_done("held_go_first");
    @(negedge clk);
    check("held_go_restart", busy, 1);
    frame_go = 1'b0;
    wait_frame_done("held_go_second");
    repeat (3) @(negedge clk);
    check("held_go_stays_idle", busy, 0);

    ready_pct = 60;
    stray_en  = 1'b1;
    for (int f = 0; f < 6; f++) begin
      salt = 24'($urandom);
      for (int i = 0; i < NPIX; i++) dly[i] = int'($urandom_range(20));
      run_frame("random");
    end

    repeat (10) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mandelbrot_pixel_sequencer.md
Name: mandelbrot_pixel_sequencer

Overview:
- Drives the per-pixel compute core: issues each (px, py) with a one-cycle start pulse, waits for done, captures the 24-bit colour.
- Streams captured pixels downstream on a valid/ready interface, with start-of-frame and end-of-line markers.
- Sits between the frame controller (frame_go) and the video/frame-buffer writer.
- Covers one raster frame per frame_go; a timeout guards against a core that never completes.

Parameters:
- H_RES, 640, pixels per line; 1..1024.
- V_RES, 480, lines per frame; 1..512.
- TIMEOUT, 4096, maximum WAIT cycles per pixel before a black pixel is forced; ≥2.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- frame_go  in  1  start one frame; sampled only in IDLE
- core_start  out  1  one-cycle start pulse to the compute core
- core_px  out  10  pixel x to core
- core_py  out  9  pixel y to core
- core_done  in  1  core completion pulse; sampled only in WAIT
- core_rgb  in  24  core colour; valid in the core_done cycle
- out_data  out  24  pixel colour
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accept
- out_sof  out  1  qualifies the pixel at (0,0)
- out_eol  out  1  qualifies the pixel at x = H_RES-1
- busy  out  1  high outside IDLE
- frame_done  out  1  one-cycle pulse after the last pixel is accepted
- timeout_err  out  1  sticky; a pixel timed out this frame

Behaviour:
- Reset (async, reset_n=0): state=IDLE; all outputs 0, including core_px/core_py, out_data and timeout_err; wait counter 0.
- All outputs are registered.
- IDLE:
  - busy=0.
  - frame_go=1 → px=0, py=0, timeout_err←0, next state ISSUE.
  - frame_go in any other state is ignored.
- ISSUE:
  - core_start=1 for exactly this one cycle.
  - core_px/core_py already hold the current coordinate and stay stable until PUSH completes.
  - Next state WAIT; wait_cnt←0.
- WAIT:
  - core_done=1 → out_data←core_rgb, out_valid←1, out_sof←(px==0 && py==0), out_eol←(px==H_RES-1); next state PUSH.
  - Otherwise, if wait_cnt==TIMEOUT-1 → out_data←0, timeout_err←1, markers as above, out_valid←1; next state PUSH.
  - Otherwise wait_cnt++.
  - core_done and timeout in the same cycle: core_done wins; timeout_err is unchanged.
- PUSH:
  - out_valid, out_data, out_sof and out_eol are held stable while out_ready=0; there is no limit on backpressure.
  - On out_valid && out_ready: out_valid, out_sof and out_eol ←0.
  - If (px,py)==(H_RES-1,V_RES-1): frame_done←1 for one cycle, next state IDLE.
  - Else advance raster (px+1; at px==H_RES-1 wrap px=0, py+1), next state ISSUE.
- core_done outside WAIT is ignored.
- Per-pixel cost: 1 (ISSUE) + N_wait + 1 (WAIT exit) + ≥1 (PUSH).
- frame_done rises in the cycle after the final handshake and coincides with busy falling.
- Reset mid-frame aborts immediately with no partial output. A pending out_valid is dropped.

Decomposition:
- Shared package mandelbrot_pkg:
  - PX_W=10, PY_W=9, RGB_W=24.
  - FSM state encoding (IDLE, ISSUE, WAIT, PUSH).
- Sub-module mandelbrot_raster_counter: holds px/py; inputs clr and adv; flags is_first, is_eol, is_last; parameterised by H_RES and V_RES.

Test Plan (H_RES=4, V_RES=2, TIMEOUT=16 unless stated):
- frame_go pulse; core model answers done 3 cycles after start with rgb={8'h00,px,py}; out_ready=1 → 8 pixels in raster order (0,0)…(3,1); out_sof only on the first; out_eol on x=3; frame_done 1 cycle after the 8th handshake; timeout_err=0.
- Same stimulus, out_ready low for 5 cycles on pixel 2 → out_data/out_valid held; no core_start issued until accepted; no pixel lost or duplicated.
- Core never answers pixel (1,0) → after 16 WAIT cycles emits out_data=0 and timeout_err=1; remaining pixels are normal; the next frame_go clears timeout_err.
- core_done pulsed during IDLE and during PUSH → ignored; no extra pixels; core_done coincident with the timeout cycle → captured rgb emitted, timeout_err stays 0.
- reset_n low while in WAIT of pixel 5 → all outputs 0 asynchronously; a new frame_go restarts at (0,0) with out_sof=1.
- frame_go held high for the entire frame → exactly one frame runs; a second frame starts only after returning to IDLE (busy toggles low for ≥1 cycle).
